// File: rtl/branch_outcome_driver_pkg.sv
// Shared widths and payload types for the branch outcome driver and its in-flight queue.
package branch_outcome_driver_pkg;

  localparam int unsigned INDEX_LEN                = 8;
  localparam int unsigned MAX_ROLLBACK_CYCLES_INCL = 4;
  localparam int unsigned DEFAULT_DEPTH            = MAX_ROLLBACK_CYCLES_INCL;
  localparam int unsigned DEFAULT_AGE_W            = $clog2(DEFAULT_DEPTH + 1);

  // One recorded prediction awaiting its execute resolution
  typedef struct packed {
    logic [INDEX_LEN-1:0]     index;
    logic                     predicted;
    logic [DEFAULT_AGE_W-1:0] age;
  } inflight_entry_t;

  // Mirrors the update fields of prediction_intf
  typedef struct packed {
    logic                     enable;
    logic [INDEX_LEN-1:0]     index;
    logic                     taken;
    logic                     is_rollback;
    logic [DEFAULT_AGE_W-1:0] no_stall_rollback_cycles;
  } update_req_t;

endpackage

// File: rtl/branch_outcome_driver_inflight_queue.sv
// Circular FIFO of in-flight predictions; each valid entry carries a saturating no-stall age.
module branch_outcome_driver_inflight_queue #(
  parameter int unsigned INDEX_LEN = branch_outcome_driver_pkg::INDEX_LEN,
  parameter int unsigned DEPTH     = branch_outcome_driver_pkg::DEFAULT_DEPTH,
  parameter int unsigned AGE_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 age_en,
  input  logic                 push,
  input  logic [INDEX_LEN-1:0] push_index,
  input  logic                 push_pred,
  input  logic                 pop,
  input  logic                 clear,
  output logic [INDEX_LEN-1:0] head_index_c,
  output logic                 head_pred_c,
  output logic [AGE_W-1:0]     head_age_c,
  output logic                 empty_c,
  output logic                 full_c
);
  import branch_outcome_driver_pkg::*;

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [INDEX_LEN-1:0] index;
    logic                 predicted;
    logic [AGE_W-1:0]     age;
  } entry_t;

  entry_t           slots [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  // Wrap explicitly so DEPTH need not be a power of two
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else if (clear) begin
      valid  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (age_en && valid[i] && (slots[i].age != AGE_W'(DEPTH))) begin
          slots[i].age <= slots[i].age + AGE_W'(1);
        end
        if (pop && (PTR_W'(i) == rd_ptr)) begin
          valid[i] <= 1'b0;
        end
        // A push into the slot being popped this edge wins (full push+pop)
        if (push && (PTR_W'(i) == wr_ptr)) begin
          valid[i] <= 1'b1;
          slots[i] <= '{index: push_index, predicted: push_pred, age: '0};
        end
      end
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push) wr_ptr <= next_ptr(wr_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_comb begin
    head_index_c = slots[rd_ptr].index;
    head_pred_c  = slots[rd_ptr].predicted;
    head_age_c   = slots[rd_ptr].age;
    empty_c      = (count == '0);
    full_c       = (count == CNT_W'(DEPTH));
  end

endmodule

// File: rtl/branch_outcome_driver.sv
// Initiator side of prediction_intf: queries, in-flight tracking, update/rollback driving.
// Optional PRED_STATS_EN adds saturating prediction/mispredict counters.
module branch_outcome_driver #(
  parameter int unsigned INDEX_LEN = branch_outcome_driver_pkg::INDEX_LEN,
  parameter int unsigned DEPTH     = branch_outcome_driver_pkg::MAX_ROLLBACK_CYCLES_INCL,
  parameter int unsigned AGE_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 is_stalling,
  input  logic                 fetch_valid,
  input  logic [INDEX_LEN-1:0] fetch_index,
  output logic                 fetch_ready,
  output logic                 pred_take,
  input  logic                 resolve_valid,
  input  logic                 resolve_taken,
  output logic [INDEX_LEN-1:0] query_index,
  input  logic                 resp_take,
  output logic                 upd_enable,
  output logic [INDEX_LEN-1:0] upd_index,
  output logic                 upd_taken,
  output logic                 upd_is_rollback,
  output logic [AGE_W-1:0]     upd_no_stall_rollback_cycles,
  output logic                 flush,
  output logic                 err_underflow
`ifdef PRED_STATS_EN
  ,
  output logic [31:0]          stat_predictions,
  output logic [31:0]          stat_mispredicts
`endif
);
  import branch_outcome_driver_pkg::*;

  logic [INDEX_LEN-1:0] head_index_c;
  logic                 head_pred_c;
  logic [AGE_W-1:0]     head_age_c;
  logic                 empty_c;
  logic                 full_c;
  logic                 resolve_hit_c;
  logic                 mispredict_now_c;
  logic                 pop_ok_c;
  logic                 push_c;

  // Resolve and mispredict detection; a mispredict clears the queue instead of popping
  always_comb begin
    resolve_hit_c    = resolve_valid && !empty_c;
    mispredict_now_c = resolve_hit_c && (head_pred_c != resolve_taken);
    pop_ok_c         = resolve_hit_c && !mispredict_now_c;
    query_index      = fetch_index;
    pred_take        = resp_take;
    fetch_ready      = !full_c || pop_ok_c;
    push_c           = fetch_valid && fetch_ready && !is_stalling && !mispredict_now_c;
  end

  branch_outcome_driver_inflight_queue #(
    .INDEX_LEN (INDEX_LEN),
    .DEPTH     (DEPTH),
    .AGE_W     (AGE_W)
  ) u_queue (
    .clk          (clk),
    .reset        (reset),
    .age_en       (!is_stalling),
    .push         (push_c),
    .push_index   (fetch_index),
    .push_pred    (resp_take),
    .pop          (resolve_hit_c),
    .clear        (mispredict_now_c),
    .head_index_c (head_index_c),
    .head_pred_c  (head_pred_c),
    .head_age_c   (head_age_c),
    .empty_c      (empty_c),
    .full_c       (full_c)
  );

  // Update/flush stage: one-cycle pulse following the resolving edge
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_enable                   <= 1'b0;
      upd_index                    <= '0;
      upd_taken                    <= 1'b0;
      upd_is_rollback              <= 1'b0;
      upd_no_stall_rollback_cycles <= '0;
      flush                        <= 1'b0;
      err_underflow                <= 1'b0;
    end else begin
      upd_enable                   <= resolve_hit_c;
      upd_index                    <= head_index_c;
      upd_taken                    <= resolve_taken;
      upd_is_rollback              <= mispredict_now_c;
      upd_no_stall_rollback_cycles <= head_age_c;
      flush                        <= mispredict_now_c;
      if (resolve_valid && empty_c) begin
        err_underflow <= 1'b1;
      end
    end
  end

`ifdef PRED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_predictions <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (resolve_hit_c && (stat_predictions != '1)) begin
        stat_predictions <= stat_predictions + 32'd1;
      end
      if (mispredict_now_c && (stat_mispredicts != '1)) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_outcome_driver.sv
// Scoreboard bench for branch_outcome_driver: expected updates queued at resolve, checked on upd_enable.
module tb_branch_outcome_driver;
  import branch_outcome_driver_pkg::*;

  localparam int unsigned IW = INDEX_LEN;
  localparam int unsigned D  = MAX_ROLLBACK_CYCLES_INCL;
  localparam int unsigned AW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          is_stalling;
  logic          fetch_valid;
  logic [IW-1:0] fetch_index;
  logic          fetch_ready;
  logic          pred_take;
  logic          resolve_valid;
  logic          resolve_taken;
  logic [IW-1:0] query_index;
  logic          resp_take;
  logic          upd_enable;
  logic [IW-1:0] upd_index;
  logic          upd_taken;
  logic          upd_is_rollback;
  logic [AW-1:0] upd_no_stall_rollback_cycles;
  logic          flush;
  logic          err_underflow;
`ifdef PRED_STATS_EN
  logic [31:0]   stat_predictions;
  logic [31:0]   stat_mispredicts;
`endif

  branch_outcome_driver dut (
    .clk                          (clk),
    .reset                        (reset),
    .is_stalling                  (is_stalling),
    .fetch_valid                  (fetch_valid),
    .fetch_index                  (fetch_index),
    .fetch_ready                  (fetch_ready),
    .pred_take                    (pred_take),
    .resolve_valid                (resolve_valid),
    .resolve_taken                (resolve_taken),
    .query_index                  (query_index),
    .resp_take                    (resp_take),
    .upd_enable                   (upd_enable),
    .upd_index                    (upd_index),
    .upd_taken                    (upd_taken),
    .upd_is_rollback              (upd_is_rollback),
    .upd_no_stall_rollback_cycles (upd_no_stall_rollback_cycles),
    .flush                        (flush),
    .err_underflow                (err_underflow)
`ifdef PRED_STATS_EN
    ,
    .stat_predictions             (stat_predictions),
    .stat_mispredicts             (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] index;
    logic          taken;
    logic          rb;
    logic [AW-1:0] age;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every emitted update against the oldest queued expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      if (upd_enable) begin
        if (sb.size() == 0) begin
          check("unexpected_upd", 32'(upd_enable), 32'd0);
        end else begin
          e = sb.pop_front();
          check("upd_index", 32'(upd_index), 32'(e.index));
          check("upd_taken", 32'(upd_taken), 32'(e.taken));
          check("upd_is_rollback", 32'(upd_is_rollback), 32'(e.rb));
          check("upd_age", 32'(upd_no_stall_rollback_cycles), 32'(e.age));
          check("flush", 32'(flush), 32'(e.rb));
        end
      end else if (flush) begin
        check("flush_without_upd", 32'(flush), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic stall);
    is_stalling = stall;
    repeat (n) step();
    is_stalling = 1'b0;
  endtask

  task automatic push_br(input logic [IW-1:0] idx, input logic take);
    fetch_valid = 1'b1;
    fetch_index = idx;
    resp_take   = take;
    #1;
    check("query_index", 32'(query_index), 32'(idx));
    check("pred_take", 32'(pred_take), 32'(take));
    step();
    fetch_valid = 1'b0;
  endtask

  task automatic resolve_br(input logic taken, input logic expect_upd,
                            input logic [IW-1:0] idx, input logic rb, input logic [AW-1:0] age);
    exp_t e;
    resolve_valid = 1'b1;
    resolve_taken = taken;
    if (expect_upd) begin
      e.index = idx; e.taken = taken; e.rb = rb; e.age = age;
      sb.push_back(e);
    end
    step();
    resolve_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    reset = 1'b1; is_stalling = 1'b0; fetch_valid = 1'b0; fetch_index = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0; resp_take = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_upd_enable", 32'(upd_enable), 32'd0);
    check("rst_upd_index", 32'(upd_index), 32'd0);
    check("rst_upd_age", 32'(upd_no_stall_rollback_cycles), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_err", 32'(err_underflow), 32'd0);
    check("rst_fetch_ready", 32'(fetch_ready), 32'd1);

    // 1: correct prediction after 3 non-stall cycles
    push_br(8'h12, 1'b1);
    idle(3, 1'b0);
    resolve_br(1'b1, 1'b1, 8'h12, 1'b0, AW'(3));
    idle(2, 1'b0);

    // 2: stalled cycles do not age the entry; mispredict rolls back
    push_br(8'h05, 1'b0);
    idle(2, 1'b1);
    idle(2, 1'b0);
    resolve_br(1'b1, 1'b1, 8'h05, 1'b1, AW'(2));
    idle(2, 1'b0);

    // 3: mispredict on head with a same-cycle fetch drops everything
    push_br(8'h21, 1'b1);
    push_br(8'h22, 1'b1);
    push_br(8'h23, 1'b0);
    fetch_valid = 1'b1; fetch_index = 8'h30; resp_take = 1'b1;
    resolve_valid = 1'b1; resolve_taken = 1'b0;
    e.index = 8'h21; e.taken = 1'b0; e.rb = 1'b1; e.age = AW'(2);
    sb.push_back(e);
    step();
    fetch_valid = 1'b0; resolve_valid = 1'b0;
    check("t3_fetch_ready", 32'(fetch_ready), 32'd1);
    check("t3_err_before", 32'(err_underflow), 32'd0);
    idle(1, 1'b0);
    resolve_br(1'b1, 1'b0, '0, 1'b0, '0);
    check("t3_err_underflow", 32'(err_underflow), 32'd1);
    idle(2, 1'b0);

    // 4: full queue, push+pop on the same edge keeps it full
    for (int i = 0; i < int'(D); i++) push_br(IW'(8'h40 + i), 1'b1);
    check("t4_full_ready", 32'(fetch_ready), 32'd0);
    fetch_valid = 1'b1; fetch_index = 8'h44; resp_take = 1'b1;
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    #1;
    check("t4_ready_on_pop", 32'(fetch_ready), 32'd1);
    e.index = 8'h40; e.taken = 1'b1; e.rb = 1'b0; e.age = AW'(3);
    sb.push_back(e);
    step();
    fetch_valid = 1'b0; resolve_valid = 1'b0;
    #1;
    check("t4_still_full", 32'(fetch_ready), 32'd0);
    for (int i = 1; i <= int'(D); i++) begin
      resolve_br(1'b1, 1'b1, IW'(8'h40 + i), 1'b0, AW'(3));
    end
    check("t4_drained_ready", 32'(fetch_ready), 32'd1);
    idle(2, 1'b0);

    // 5: age saturates at DEPTH
    push_br(8'h55, 1'b1);
    idle(int'(D) + 2, 1'b0);
    resolve_br(1'b1, 1'b1, 8'h55, 1'b0, AW'(D));
    idle(2, 1'b0);
`ifdef PRED_STATS_EN
    check("stat_predictions", stat_predictions, 32'd9);
    check("stat_mispredicts", stat_mispredicts, 32'd2);
`endif

    // 6: reset with entries in flight drops them silently
    push_br(8'h61, 1'b1);
    push_br(8'h62, 1'b0);
    idle(1, 1'b0);
    reset = 1'b1;
    step();
    check("t6_upd_in_reset", 32'(upd_enable), 32'd0);
    reset = 1'b0;
    #1;
    check("t6_err_cleared", 32'(err_underflow), 32'd0);
    check("t6_fetch_ready", 32'(fetch_ready), 32'd1);
`ifdef PRED_STATS_EN
    check("t6_stat_pred", stat_predictions, 32'd0);
    check("t6_stat_misp", stat_mispredicts, 32'd0);
`endif
    resolve_br(1'b1, 1'b0, '0, 1'b0, '0);
    check("t6_err_underflow", 32'(err_underflow), 32'd1);
    idle(3, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
